// File: rtl/mem_wb_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_reg_if
// Description : MEM->WB handshake bundle, register-file write fields, and the
//               optional forwarding lookup (only when MEMWB_FWD_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_reg_if;
  logic        io_from_mem_valid;
  logic        io_from_mem_ready;
  logic        io_from_mem_writeEnable;
  logic [4:0]  io_from_mem_writeAddr;
  logic [31:0] io_from_mem_result;

  logic        io_to_wb_valid;
  logic        io_to_wb_ready;
  logic        io_to_wb_writeEnable;
  logic [4:0]  io_to_wb_writeAddr;
  logic [31:0] io_to_wb_result;

  logic        io_flush;

`ifdef MEMWB_FWD_EN
  logic [4:0]  io_fwd_addrA;
  logic [4:0]  io_fwd_addrB;
  logic        io_fwd_hitA;
  logic        io_fwd_hitB;
  logic [31:0] io_fwd_dataA;
  logic [31:0] io_fwd_dataB;
`endif

  // master: the side that drives the stage (MEM producer / WB consumer)
  modport master (
    output io_from_mem_valid, io_from_mem_writeEnable, io_from_mem_writeAddr,
           io_from_mem_result, io_to_wb_ready, io_flush,
`ifdef MEMWB_FWD_EN
    output io_fwd_addrA, io_fwd_addrB,
    input  io_fwd_hitA, io_fwd_hitB, io_fwd_dataA, io_fwd_dataB,
`endif
    input  io_from_mem_ready, io_to_wb_valid, io_to_wb_writeEnable,
           io_to_wb_writeAddr, io_to_wb_result
  );

  modport slave (
    input  io_from_mem_valid, io_from_mem_writeEnable, io_from_mem_writeAddr,
           io_from_mem_result, io_to_wb_ready, io_flush,
`ifdef MEMWB_FWD_EN
    input  io_fwd_addrA, io_fwd_addrB,
    output io_fwd_hitA, io_fwd_hitB, io_fwd_dataA, io_fwd_dataB,
`endif
    output io_from_mem_ready, io_to_wb_valid, io_to_wb_writeEnable,
           io_to_wb_writeAddr, io_to_wb_result
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register with a one-entry skid buffer so that
//               ready toward MEM is registered. Optional forwarding lookup is
//               enabled with the MEMWB_FWD_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg (
  input  wire           clock,
  input  wire           reset,
  mem_wb_reg_if.slave   bus
);

  localparam logic [4:0] c_ZERO_REG = 5'd0;

  logic        r_main_valid;
  logic        r_main_we;
  logic [4:0]  r_main_addr;
  logic [31:0] r_main_result;

  logic        r_skid_valid;
  logic        r_skid_we;
  logic [4:0]  r_skid_addr;
  logic [31:0] r_skid_result;

  logic w_accept;
  logic w_in_we;
  logic w_drain;
  logic w_main_free;

  assign w_accept    = bus.io_from_mem_valid & ~r_skid_valid & ~bus.io_flush;
  // writes to $zero are squashed at capture so WB and forwarding never see them
  assign w_in_we     = bus.io_from_mem_writeEnable & (bus.io_from_mem_writeAddr != c_ZERO_REG);
  assign w_drain     = r_main_valid & bus.io_to_wb_ready;
  assign w_main_free = ~r_main_valid | w_drain;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_main_valid  <= 1'b0;
      r_main_we     <= 1'b0;
      r_main_addr   <= 5'd0;
      r_main_result <= 32'd0;
      r_skid_valid  <= 1'b0;
      r_skid_we     <= 1'b0;
      r_skid_addr   <= 5'd0;
      r_skid_result <= 32'd0;
    end else if (bus.io_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_valid  <= 1'b1;
        r_main_we     <= r_skid_we;
        r_main_addr   <= r_skid_addr;
        r_main_result <= r_skid_result;
        // skid was full so ready was low; nothing can be accepted behind it
        r_skid_valid  <= w_accept;
        if (w_accept) begin
          r_skid_we     <= w_in_we;
          r_skid_addr   <= bus.io_from_mem_writeAddr;
          r_skid_result <= bus.io_from_mem_result;
        end
      end else if (w_accept) begin
        r_main_valid  <= 1'b1;
        r_main_we     <= w_in_we;
        r_main_addr   <= bus.io_from_mem_writeAddr;
        r_main_result <= bus.io_from_mem_result;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid  <= 1'b1;
      r_skid_we     <= w_in_we;
      r_skid_addr   <= bus.io_from_mem_writeAddr;
      r_skid_result <= bus.io_from_mem_result;
    end
  end

  assign bus.io_from_mem_ready    = ~r_skid_valid;
  assign bus.io_to_wb_valid       = r_main_valid;
  assign bus.io_to_wb_writeEnable = r_main_valid & r_main_we;
  assign bus.io_to_wb_writeAddr   = r_main_addr;
  assign bus.io_to_wb_result      = r_main_result;

`ifdef MEMWB_FWD_EN
  logic w_skid_hit_a, w_main_hit_a, w_skid_hit_b, w_main_hit_b;

  // skid holds the younger result, so it takes priority over main
  assign w_skid_hit_a = (bus.io_fwd_addrA != c_ZERO_REG) & r_skid_valid & r_skid_we &
                        (r_skid_addr == bus.io_fwd_addrA);
  assign w_main_hit_a = (bus.io_fwd_addrA != c_ZERO_REG) & r_main_valid & r_main_we &
                        (r_main_addr == bus.io_fwd_addrA);
  assign w_skid_hit_b = (bus.io_fwd_addrB != c_ZERO_REG) & r_skid_valid & r_skid_we &
                        (r_skid_addr == bus.io_fwd_addrB);
  assign w_main_hit_b = (bus.io_fwd_addrB != c_ZERO_REG) & r_main_valid & r_main_we &
                        (r_main_addr == bus.io_fwd_addrB);

  assign bus.io_fwd_hitA  = w_skid_hit_a | w_main_hit_a;
  assign bus.io_fwd_hitB  = w_skid_hit_b | w_main_hit_b;
  assign bus.io_fwd_dataA = w_skid_hit_a ? r_skid_result :
                            w_main_hit_a ? r_main_result : 32'd0;
  assign bus.io_fwd_dataB = w_skid_hit_b ? r_skid_result :
                            w_main_hit_b ? r_main_result : 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_reg.sv
`default_nettype none
// Directed self-checking bench for mem_wb_reg; forwarding checks are built
// only when MEMWB_FWD_EN is defined.
module tb_mem_wb_reg;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  mem_wb_reg_if bus ();

  mem_wb_reg dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<1ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] r);
    bus.io_from_mem_valid       = v;
    bus.io_from_mem_writeEnable = we;
    bus.io_from_mem_writeAddr   = a;
    bus.io_from_mem_result      = r;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #2;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    bus.io_to_wb_ready = 1'b1;
    bus.io_flush       = 1'b0;
    reset = 1'b0;
    step();
    tests++;
    if ({bus.io_to_wb_valid, bus.io_to_wb_writeEnable, bus.io_to_wb_writeAddr,
         bus.io_to_wb_result, bus.io_from_mem_ready} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got v=%b we=%b a=%0d r=%h rdy=%b, required v=0 we=0 a=0 r=0 rdy=1",
               bus.io_to_wb_valid, bus.io_to_wb_writeEnable, bus.io_to_wb_writeAddr,
               bus.io_to_wb_result, bus.io_from_mem_ready);
    end
    reset = 1'b1;
    #2;
  endtask

  task automatic test_basic();
    bus.io_to_wb_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    tests++;
    if ({bus.io_to_wb_valid, bus.io_to_wb_writeEnable, bus.io_to_wb_writeAddr,
         bus.io_to_wb_result} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL basic_latency: got v=%b we=%b a=%0d r=%h, required v=1 we=1 a=5 r=deadbeef",
               bus.io_to_wb_valid, bus.io_to_wb_writeEnable, bus.io_to_wb_writeAddr, bus.io_to_wb_result);
    end
    step();
    tests++;
    if (bus.io_to_wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain: got v=%b, required v=0", bus.io_to_wb_valid);
    end
  endtask

  task automatic test_skid();
    bus.io_to_wb_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'h0000_000A);
    step();
    drive(1'b1, 1'b1, 5'd4, 32'h0000_000B);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    tests++;
    if ({bus.io_from_mem_ready, bus.io_to_wb_valid, bus.io_to_wb_writeAddr} !== {1'b0, 1'b1, 5'd3}) begin
      fails++;
      $display("FAIL skid_full: got rdy=%b v=%b a=%0d, required rdy=0 v=1 a=3",
               bus.io_from_mem_ready, bus.io_to_wb_valid, bus.io_to_wb_writeAddr);
    end
    step();
    tests++;
    if ({bus.io_to_wb_valid, bus.io_to_wb_writeAddr, bus.io_to_wb_result} !== {1'b1, 5'd3, 32'h0000_000A}) begin
      fails++;
      $display("FAIL skid_hold: got v=%b a=%0d r=%h, required v=1 a=3 r=0000000a",
               bus.io_to_wb_valid, bus.io_to_wb_writeAddr, bus.io_to_wb_result);
    end
    bus.io_to_wb_ready = 1'b1;
    step();
    tests++;
    if ({bus.io_to_wb_valid, bus.io_to_wb_writeAddr, bus.io_to_wb_result, bus.io_from_mem_ready}
        !== {1'b1, 5'd4, 32'h0000_000B, 1'b1}) begin
      fails++;
      $display("FAIL skid_second: got v=%b a=%0d r=%h rdy=%b, required v=1 a=4 r=0000000b rdy=1",
               bus.io_to_wb_valid, bus.io_to_wb_writeAddr, bus.io_to_wb_result, bus.io_from_mem_ready);
    end
    step();
    tests++;
    if (bus.io_to_wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL skid_empty: got v=%b, required v=0", bus.io_to_wb_valid);
    end
  endtask

  task automatic test_zero_addr();
    bus.io_to_wb_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd0, 32'h0000_1234);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    tests++;
    if ({bus.io_to_wb_valid, bus.io_to_wb_writeEnable, bus.io_to_wb_result} !== {1'b1, 1'b0, 32'h0000_1234}) begin
      fails++;
      $display("FAIL zero_addr: got v=%b we=%b r=%h, required v=1 we=0 r=00001234",
               bus.io_to_wb_valid, bus.io_to_wb_writeEnable, bus.io_to_wb_result);
    end
    step();
  endtask

  // fills main (addr 7 = 0x11) and skid (addr 7 = 0x22), probes forwarding, then flushes
  task automatic test_flush();
    bus.io_to_wb_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd7, 32'h0000_0011);
    step();
    drive(1'b1, 1'b1, 5'd7, 32'h0000_0022);
    step();
`ifdef MEMWB_FWD_EN
    bus.io_fwd_addrA = 5'd7;
    bus.io_fwd_addrB = 5'd0;
    #1;
    tests++;
    if ({bus.io_fwd_hitA, bus.io_fwd_dataA, bus.io_fwd_hitB, bus.io_fwd_dataB}
        !== {1'b1, 32'h0000_0022, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL fwd_skid_priority: got hitA=%b dataA=%h hitB=%b dataB=%h, required 1 00000022 0 00000000",
               bus.io_fwd_hitA, bus.io_fwd_dataA, bus.io_fwd_hitB, bus.io_fwd_dataB);
    end
    bus.io_fwd_addrB = 5'd9;
    #1;
    tests++;
    if ({bus.io_fwd_hitB, bus.io_fwd_dataB} !== {1'b0, 32'd0}) begin
      fails++;
      $display("FAIL fwd_miss: got hitB=%b dataB=%h, required 0 00000000", bus.io_fwd_hitB, bus.io_fwd_dataB);
    end
`endif
    drive(1'b1, 1'b1, 5'd7, 32'h0000_0033);
    bus.io_flush = 1'b1;
    step();
    bus.io_flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    tests++;
    if ({bus.io_to_wb_valid, bus.io_from_mem_ready} !== {1'b0, 1'b1}) begin
      fails++;
      $display("FAIL flush_clear: got v=%b rdy=%b, required v=0 rdy=1", bus.io_to_wb_valid, bus.io_from_mem_ready);
    end
    bus.io_to_wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.io_to_wb_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_no_leak: cycle %0d got v=%b r=%h, required v=0", i, bus.io_to_wb_valid, bus.io_to_wb_result);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad_rdy;
    int bad_out;
    bad_rdy = 0;
    bad_out = 0;
    bus.io_to_wb_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) drive(1'b1, 1'b1, 5'((i % 31) + 1), 32'(i * 3 + 1));
      else         drive(1'b0, 1'b0, 5'd0, 32'd0);
      if (bus.io_from_mem_ready !== 1'b1) bad_rdy++;
      step();
      if (i < 100) begin
        if ({bus.io_to_wb_valid, bus.io_to_wb_writeAddr, bus.io_to_wb_result}
            !== {1'b1, 5'((i % 31) + 1), 32'(i * 3 + 1)}) begin
          bad_out++;
          if (bad_out == 1)
            $display("FAIL stream_item_%0d: got v=%b a=%0d r=%h, required v=1 a=%0d r=%h", i,
                     bus.io_to_wb_valid, bus.io_to_wb_writeAddr, bus.io_to_wb_result,
                     (i % 31) + 1, 32'(i * 3 + 1));
        end
      end
    end
    tests++;
    if (bad_out !== 0) begin
      fails++;
      $display("FAIL stream_order: got %0d bad cycles, required 0", bad_out);
    end
    tests++;
    if (bad_rdy !== 0) begin
      fails++;
      $display("FAIL stream_ready: got %0d cycles with ready low, required 0", bad_rdy);
    end
  endtask

  task automatic test_async_reset();
    bus.io_to_wb_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd2, 32'h0000_0055);
    step();
    drive(1'b1, 1'b1, 5'd6, 32'h0000_0066);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.io_to_wb_valid, bus.io_from_mem_ready, bus.io_to_wb_result} !== {1'b0, 1'b1, 32'd0}) begin
      fails++;
      $display("FAIL async_reset: got v=%b rdy=%b r=%h, required v=0 rdy=1 r=0",
               bus.io_to_wb_valid, bus.io_from_mem_ready, bus.io_to_wb_result);
    end
    #1;
    reset = 1'b1;
    bus.io_to_wb_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 32'h0000_0099);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    tests++;
    if ({bus.io_to_wb_valid, bus.io_to_wb_writeAddr, bus.io_to_wb_result} !== {1'b1, 5'd9, 32'h0000_0099}) begin
      fails++;
      $display("FAIL post_reset_accept: got v=%b a=%0d r=%h, required v=1 a=9 r=00000099",
               bus.io_to_wb_valid, bus.io_to_wb_writeAddr, bus.io_to_wb_result);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.io_flush = 1'b0;
    bus.io_to_wb_ready = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
`ifdef MEMWB_FWD_EN
    bus.io_fwd_addrA = 5'd0;
    bus.io_fwd_addrB = 5'd0;
`endif
    test_reset();
    test_basic();
    test_skid();
    test_zero_addr();
    test_flush();
    do_reset();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
